// File: rtl/matmul_controller.sv
// Tile matrix-multiply controller: C = A x W on an MxM FP64 tile using N multiply-add lanes.
// Define MATMUL_CTRL_BUSY_OUT_EN to add the busy output (high while computing).
module matmul_controller #(
  parameter int M = 3,
  parameter int N = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
`ifdef MATMUL_CTRL_BUSY_OUT_EN
  output logic              busy,
`endif
  input  logic              output_stationary,
  input  logic [64*M*M-1:0] A_tile_flat,
  input  logic [64*M*M-1:0] W_tile_flat,
  output logic [64*M*M-1:0] C_tile_flat,
  input  logic [7:0]        k1,
  input  logic [7:0]        k2,
  input  logic [7:0]        k3
);
  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

  function automatic logic is_nan(input logic [63:0] x);
    return (x[62:52] == 11'h7ff) && (x[51:0] != 52'h0);
  endfunction

  function automatic logic is_inf(input logic [63:0] x);
    return (x[62:52] == 11'h7ff) && (x[51:0] == 52'h0);
  endfunction

  function automatic logic [63:0] quiet(input logic [63:0] x);
    return {x[63], 11'h7ff, 1'b1, x[50:0]};
  endfunction

  function automatic logic [52:0] mant(input logic [63:0] x);
    return {x[62:52] != 11'h0, x[51:0]};
  endfunction

  function automatic int expo(input logic [63:0] x);
    return (x[62:52] == 11'h0) ? 1 : int'(x[62:52]);
  endfunction

  // Normalizes a nonzero significand (biased exponent = base - leading zeros) and rounds to nearest-even.
  function automatic logic [63:0] round_pack(input logic s, input int base, input logic [127:0] sig_in);
    logic [127:0] sig;
    logic [52:0]  m;
    logic         grd, st, inc;
    logic [62:0]  field;
    int           lz, e, sh;
    lz = 0;
    for (int b = 0; b < 128; b++) if (sig_in[b]) lz = 127 - b;
    sig = sig_in << lz;
    e = base - lz;
    if (e >= 2047) return {s, 11'h7ff, 52'h0};
    if (e < 1) begin
      sh  = (1 - e > 127) ? 127 : 1 - e;
      st  = |(sig & ((128'h1 << sh) - 128'h1));
      sig = (sig >> sh) | {127'h0, st};
      e   = 0;
    end
    m     = sig[127:75];
    grd   = sig[74];
    st    = |sig[73:0];
    inc   = grd & (st | m[0]);
    field = {e[10:0], m[51:0]} + {62'h0, inc};
    return {s, field};
  endfunction

  function automatic logic [63:0] fp_mul(input logic [63:0] a, input logic [63:0] b);
    logic         s, a_zero, b_zero;
    logic [105:0] prod;
    s      = a[63] ^ b[63];
    a_zero = (a[62:0] == 63'h0);
    b_zero = (b[62:0] == 63'h0);
    if (is_nan(a)) return quiet(a);
    if (is_nan(b)) return quiet(b);
    if ((is_inf(a) && b_zero) || (is_inf(b) && a_zero)) return QNAN;
    if (is_inf(a) || is_inf(b)) return {s, 11'h7ff, 52'h0};
    if (a_zero || b_zero) return {s, 63'h0};
    prod = 106'(mant(a)) * 106'(mant(b));
    return round_pack(s, expo(a) + expo(b) - 1000, {22'h0, prod});
  endfunction

  function automatic logic [63:0] fp_add(input logic [63:0] a, input logic [63:0] b);
    logic [63:0]  x, y;
    logic [127:0] sx, sy, sum;
    logic         st;
    int           d;
    if (is_nan(a)) return quiet(a);
    if (is_nan(b)) return quiet(b);
    if (is_inf(a) && is_inf(b) && (a[63] != b[63])) return QNAN;
    if (is_inf(a)) return a;
    if (is_inf(b)) return b;
    if ((a[62:0] == 63'h0) && (b[62:0] == 63'h0)) return {a[63] & b[63], 63'h0};
    if (a[62:0] >= b[62:0]) begin x = a; y = b; end
    else begin x = b; y = a; end
    d  = expo(x) - expo(y);
    if (d > 127) d = 127;
    sx = {11'h0, mant(x), 64'h0};
    sy = {11'h0, mant(y), 64'h0};
    st = |(sy & ((128'h1 << d) - 128'h1));
    sy = (sy >> d) | {127'h0, st};
    sum = (x[63] == y[63]) ? sx + sy : sx - sy;
    if (sum == 128'h0) return 64'h0;
    return round_pack(x[63], expo(x) + 11, sum);
  endfunction

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t      state_reg;
  logic [63:0] a_reg [M*M];
  logic [63:0] w_reg [M*M];
  logic [63:0] c_reg [M*M];
  logic [63:0] acc_reg [N];
  logic [7:0]  k1_reg, k2_reg, k3_reg, g_last_reg;
  logic [7:0]  i_reg, k_reg, g_reg;
  logic        os_reg, fin_reg;
  logic [7:0]  k1_c, k2_c, k3_c;
  logic        last_i, last_g, last_k;
  logic [63:0] lane_sum [N];
  logic        lane_wr [N];
  int          lane_cidx [N];

  assign k1_c   = (k1 > 8'(M)) ? 8'(M) : k1;
  assign k2_c   = (k2 > 8'(M)) ? 8'(M) : k2;
  assign k3_c   = (k3 > 8'(M)) ? 8'(M) : k3;
  assign last_i = (i_reg == k1_reg - 8'd1);
  assign last_k = (k_reg == k2_reg - 8'd1);
  assign last_g = (g_reg == g_last_reg);

`ifdef MATMUL_CTRL_BUSY_OUT_EN
  assign busy = (state_reg == COMPUTE);
`endif

  for (genvar gi = 0; gi < M*M; gi++) begin : g_cout
    assign C_tile_flat[64*gi +: 64] = c_reg[gi];
  end

  // Each lane owns column g*N+gi; idle lanes point at a safe index and never write.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    int          j;
    logic        act;
    logic [63:0] addend, sum;
    always_comb begin
      j   = int'(g_reg) * N + gi;
      act = (j < int'(k3_reg));
      if (!act) j = 0;
      if (os_reg) addend = (k_reg == 8'd0) ? 64'h0 : acc_reg[gi];
      else        addend = c_reg[int'(i_reg) * M + j];
      sum = fp_add(addend, fp_mul(a_reg[int'(i_reg) * M + int'(k_reg)], w_reg[int'(k_reg) * M + j]));
    end
    assign lane_sum[gi]  = sum;
    assign lane_wr[gi]   = act && (!os_reg || last_k);
    assign lane_cidx[gi] = int'(i_reg) * M + j;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      done       <= 1'b0;
      fin_reg    <= 1'b0;
      os_reg     <= 1'b0;
      i_reg      <= 8'd0;
      k_reg      <= 8'd0;
      g_reg      <= 8'd0;
      k1_reg     <= 8'd0;
      k2_reg     <= 8'd0;
      k3_reg     <= 8'd0;
      g_last_reg <= 8'd0;
      for (int e = 0; e < M*M; e++) c_reg[e] <= 64'h0;
      for (int l = 0; l < N; l++) acc_reg[l] <= 64'h0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg  <= COMPUTE;
            done       <= 1'b0;
            os_reg     <= output_stationary;
            k1_reg     <= k1_c;
            k2_reg     <= k2_c;
            k3_reg     <= k3_c;
            g_last_reg <= (k3_c == 8'd0) ? 8'd0 : 8'((int'(k3_c) - 1) / N);
            i_reg      <= 8'd0;
            k_reg      <= 8'd0;
            g_reg      <= 8'd0;
            fin_reg    <= (k1_c == 8'd0) || (k2_c == 8'd0) || (k3_c == 8'd0);
            for (int e = 0; e < M*M; e++) begin
              a_reg[e] <= A_tile_flat[64*e +: 64];
              w_reg[e] <= W_tile_flat[64*e +: 64];
              c_reg[e] <= 64'h0;
            end
          end
        end
        COMPUTE: begin
          if (fin_reg) begin
            state_reg <= DONE;
            done      <= 1'b1;
            fin_reg   <= 1'b0;
          end else begin
            for (int l = 0; l < N; l++) begin
              acc_reg[l] <= lane_sum[l];
              if (lane_wr[l]) c_reg[lane_cidx[l]] <= lane_sum[l];
            end
            if (os_reg) begin
              if (!last_k) k_reg <= k_reg + 8'd1;
              else begin
                k_reg <= 8'd0;
                if (!last_g) g_reg <= g_reg + 8'd1;
                else begin
                  g_reg <= 8'd0;
                  if (!last_i) i_reg <= i_reg + 8'd1;
                  else begin i_reg <= 8'd0; fin_reg <= 1'b1; end
                end
              end
            end else begin
              if (!last_i) i_reg <= i_reg + 8'd1;
              else begin
                i_reg <= 8'd0;
                if (!last_g) g_reg <= g_reg + 8'd1;
                else begin
                  g_reg <= 8'd0;
                  if (!last_k) k_reg <= k_reg + 8'd1;
                  else begin k_reg <= 8'd0; fin_reg <= 1'b1; end
                end
              end
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matmul_controller.sv
// Directed table-driven bench for matmul_controller (3x3 tile, 3 lanes) plus multi-cycle corner sequences.
module tb_matmul_controller;
  localparam int M  = 3;
  localparam int N  = 3;
  localparam int TW = 64*M*M;

  logic          clk = 1'b0;
  logic          reset, start, done, output_stationary;
  logic [TW-1:0] A_tile_flat, W_tile_flat, C_tile_flat;
  logic [7:0]    k1, k2, k3;
`ifdef MATMUL_CTRL_BUSY_OUT_EN
  logic          busy;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  matmul_controller #(.M(M), .N(N)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .done              (done),
`ifdef MATMUL_CTRL_BUSY_OUT_EN
    .busy              (busy),
`endif
    .output_stationary (output_stationary),
    .A_tile_flat       (A_tile_flat),
    .W_tile_flat       (W_tile_flat),
    .C_tile_flat       (C_tile_flat),
    .k1                (k1),
    .k2                (k2),
    .k3                (k3)
  );

  typedef struct {
    logic          os;
    logic [7:0]    k1, k2, k3;
    logic [TW-1:0] a, w, c;
    int            edges;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [TW-1:0] t9(input real e0, input real e1, input real e2,
                                       input real e3, input real e4, input real e5,
                                       input real e6, input real e7, input real e8);
    return {$realtobits(e8), $realtobits(e7), $realtobits(e6), $realtobits(e5), $realtobits(e4),
            $realtobits(e3), $realtobits(e2), $realtobits(e1), $realtobits(e0)};
  endfunction

  function automatic vec_t mk(input logic os, input int a1, input int a2, input int a3,
                              input logic [TW-1:0] a, input logic [TW-1:0] w,
                              input logic [TW-1:0] c, input int edges);
    vec_t v;
    v.os = os; v.k1 = 8'(a1); v.k2 = 8'(a2); v.k3 = 8'(a3);
    v.a = a; v.w = w; v.c = c; v.edges = edges;
    return v;
  endfunction

  task automatic check_c(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: C got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    output_stationary = v.os;
    k1 = v.k1; k2 = v.k2; k3 = v.k3;
    A_tile_flat = v.a;
    W_tile_flat = v.w;
  endtask

  // Counts rising edges until done reads 1 (sampled on the falling edge), bounded.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!done && n < 200);
  endtask

  task automatic run_vec(input int idx);
    int n;
    @(negedge clk);
    drive(vecs[idx]);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check_int($sformatf("vec%0d_edges", idx), n, vecs[idx].edges);
    check_c($sformatf("vec%0d_c", idx), C_tile_flat, vecs[idx].c);
    $display("vec %0d os=%0d k=%0d/%0d/%0d edges=%0d C0=%h", idx, vecs[idx].os,
             vecs[idx].k1, vecs[idx].k2, vecs[idx].k3, n, C_tile_flat[63:0]);
  endtask

  initial begin
    real gb;
    logic [TW-1:0] a19, ident, c19, zero;
    int n;
    gb    = 99.0;
    zero  = '0;
    a19   = t9(1, 2, 3, 4, 5, 6, 7, 8, 9);
    ident = t9(1, 0, 0, 0, 1, 0, 0, 0, 1);
    c19   = a19;

    vecs[0]  = mk(1'b0, 3, 3, 3, a19, ident, c19, 10);
    vecs[1]  = mk(1'b1, 3, 3, 3, a19, ident, c19, 10);
    vecs[2]  = mk(1'b0, 2, 2, 2, t9(1, 2, gb, 3, 4, gb, gb, gb, gb),
                  t9(2, 3, gb, 4, 5, gb, gb, gb, gb), t9(10, 13, 0, 22, 29, 0, 0, 0, 0), 5);
    vecs[3]  = vecs[2]; vecs[3].os = 1'b1;
    vecs[4]  = mk(1'b0, 1, 1, 1, t9(5, gb, gb, gb, gb, gb, gb, gb, gb),
                  t9(7, gb, gb, gb, gb, gb, gb, gb, gb), t9(35, 0, 0, 0, 0, 0, 0, 0, 0), 2);
    vecs[5]  = vecs[4]; vecs[5].os = 1'b1;
    vecs[6]  = mk(1'b0, 2, 3, 2, t9(1, 2, 3, 4, 5, 6, gb, gb, gb),
                  t9(1, 2, gb, 3, 4, gb, 5, 6, gb), t9(22, 28, 0, 49, 64, 0, 0, 0, 0), 7);
    vecs[7]  = vecs[6]; vecs[7].os = 1'b1;
    vecs[8]  = mk(1'b0, 0, 3, 3, a19, ident, zero, 1);
    vecs[9]  = mk(1'b1, 3, 3, 0, a19, ident, zero, 1);
    vecs[10] = mk(1'b1, 5, 5, 5, a19, ident, c19, 10);
    vecs[11] = mk(1'b0, 1, 2, 1, t9(-1.5, 0.25, gb, gb, gb, gb, gb, gb, gb),
                  t9(2, gb, gb, 4, gb, gb, gb, gb, gb), t9(-2.0, 0, 0, 0, 0, 0, 0, 0, 0), 3);
    vecs[12] = mk(1'b1, 1, 1, 1, t9(gb, gb, gb, gb, gb, gb, gb, gb, gb),
                  t9(-2, gb, gb, gb, gb, gb, gb, gb, gb), zero, 2);
    vecs[12].a[63:0] = 64'h7FF0_0000_0000_0000;
    vecs[12].c[63:0] = 64'hFFF0_0000_0000_0000;
    vecs[13] = mk(1'b0, 1, 2, 1, t9(1, 1, gb, gb, gb, gb, gb, gb, gb),
                  t9(1, gb, gb, -1, gb, gb, gb, gb, gb), zero, 3);
    vecs[14] = mk(1'b1, 1, 2, 1, t9(1, gb, gb, gb, gb, gb, gb, gb, gb),
                  t9(1, gb, gb, 1, gb, gb, gb, gb, gb), zero, 3);
    vecs[14].a[127:64] = 64'h3CA8_0000_0000_0000;
    vecs[14].c[63:0]   = 64'h3FF0_0000_0000_0001;
    vecs[15] = vecs[14]; vecs[15].os = 1'b0;
    vecs[15].a[127:64] = 64'h3CA0_0000_0000_0000;
    vecs[15].c[63:0]   = 64'h3FF0_0000_0000_0000;

    reset = 1'b1; start = 1'b0;
    drive(vecs[0]);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_int("reset_done", int'(done), 0);
    check_c("reset_c", C_tile_flat, zero);
    reset = 1'b0;

    for (int v = 0; v < 16; v++) run_vec(v);

    // Reset in the middle of a weight-stationary run, then a fresh run.
    @(negedge clk);
    drive(vecs[0]); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_int("midrst_done", int'(done), 0);
    check_c("midrst_c", C_tile_flat, zero);
    reset = 1'b0;
    $display("seq midrst done=%0d C0=%h", done, C_tile_flat[63:0]);
    run_vec(6);

    // start pulse with different inputs during COMPUTE must be ignored.
    @(negedge clk);
    drive(vecs[0]); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(vecs[4]); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    wait_done(n);
    check_int("ignstart_edges", n + 3, 10);
    check_c("ignstart_c", C_tile_flat, c19);
    $display("seq ignstart edges=%0d C0=%h", n + 3, C_tile_flat[63:0]);

    // Input changes while in DONE have no effect.
    A_tile_flat = t9(gb, gb, gb, gb, gb, gb, gb, gb, gb);
    k1 = 8'd1; output_stationary = 1'b1;
    repeat (3) @(negedge clk);
    check_int("hold_done", int'(done), 1);
    check_c("hold_c", C_tile_flat, c19);
    $display("seq hold done=%0d C0=%h", done, C_tile_flat[63:0]);

    // start held high: each DONE entry restarts, done pulses one cycle.
    @(negedge clk);
    drive(vecs[2]); start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wait_done(n);
    check_int("held_edges1", n, 5);
    check_c("held_c1", C_tile_flat, vecs[2].c);
    @(posedge clk);
    @(negedge clk);
    check_int("held_pulse", int'(done), 0);
    check_c("held_clear", C_tile_flat, zero);
    wait_done(n);
    start = 1'b0;
    check_int("held_edges2", n, 5);
    check_c("held_c2", C_tile_flat, vecs[2].c);
    $display("seq held edges=%0d C0=%h", n, C_tile_flat[63:0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
